// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline stall-control bundle: hazard/op status in from the stages, stall bus and status out.
// master = pipeline side, slave = stall controller.
interface pipe_stall_ctrl_if;
    logic        ex_load;
    logic [4:0]  ex_waddr;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        ex_mc_op;
    logic        mem_stallreq;
    logic [5:0]  stall;
    logic        lu_hazard;
    logic        mc_busy;
    logic        mc_done;
    logic [15:0] stall_cycles;

    modport master (
        output ex_load, ex_waddr, id_rs, id_rt, id_rs_used, id_rt_used, ex_mc_op, mem_stallreq,
        input  stall, lu_hazard, mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  ex_load, ex_waddr, id_rs, id_rt, id_rs_used, id_rt_used, ex_mc_op, mem_stallreq,
        output stall, lu_hazard, mc_busy, mc_done, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall sequencer for the 5-stage pipe: load-use bubbles, multi-cycle EX ops, data-SRAM wait merge.
// Zero latency: stall is combinational from state and inputs; mem_stallreq freezes the LU wait counter.
module pipe_stall_ctrl #(
    parameter int unsigned LU_PENALTY = 1,
    parameter int unsigned MC_CYCLES  = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_stall_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LU_WAIT = 2'd1,
        MC_BUSY = 2'd2,
        MC_DONE = 2'd3
    } state_t;

    localparam logic [5:0]  STALL_MEM = 6'b011111;
    localparam logic [5:0]  STALL_MC  = 6'b001111;
    localparam logic [5:0]  STALL_LU  = 6'b000111;
    localparam int unsigned LU_INIT   = (LU_PENALTY > 1) ? (LU_PENALTY - 2) : 0;
    localparam logic [7:0]  LU_LOAD   = 8'(LU_INIT);
    localparam logic [7:0]  MC_LOAD   = 8'(MC_CYCLES - 2);
    localparam bit          LU_MULTI  = (LU_PENALTY > 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic        hz;
    logic        mc_stall;
    logic        lu_stall;
    logic        lu_hazard_c;
    logic        mc_busy_c;
    logic        mc_done_c;
    logic [5:0]  stall_c;

    always_comb begin
        hz = bus.ex_load && (bus.ex_waddr != 5'd0) &&
             ((bus.id_rs_used && (bus.id_rs == bus.ex_waddr)) ||
              (bus.id_rt_used && (bus.id_rt == bus.ex_waddr)));

        state_d     = state_q;
        cnt_d       = cnt_q;
        mc_stall    = 1'b0;
        lu_stall    = 1'b0;
        lu_hazard_c = 1'b0;
        mc_busy_c   = 1'b0;
        mc_done_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ex_mc_op) begin
                    mc_stall  = 1'b1;
                    mc_busy_c = 1'b1;
                    state_d   = MC_BUSY;
                    cnt_d     = MC_LOAD;
                end else if (hz && !bus.mem_stallreq) begin
                    lu_stall    = 1'b1;
                    lu_hazard_c = 1'b1;
                    if (LU_MULTI) begin
                        state_d = LU_WAIT;
                        cnt_d   = LU_LOAD;
                    end
                end
            end
            LU_WAIT: begin
                lu_stall    = 1'b1;
                lu_hazard_c = 1'b1;
                if (!bus.mem_stallreq) begin
                    if (cnt_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            MC_BUSY: begin
                // Counts down even under a memory stall so EX sees a fixed op length.
                mc_stall  = 1'b1;
                mc_busy_c = 1'b1;
                if (cnt_q == 8'd0) begin
                    state_d = MC_DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            MC_DONE: begin
                mc_done_c = 1'b1;
                if (!bus.mem_stallreq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.mem_stallreq) begin
            stall_c = STALL_MEM;
        end else if (mc_stall) begin
            stall_c = STALL_MC;
        end else if (lu_stall) begin
            stall_c = STALL_LU;
        end else begin
            stall_c = 6'b000000;
        end

        stall_cycles_d = stall_cycles_q;
        if (stall_c[0] && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Combinational outputs are masked so nothing leaks out while reset is held.
    assign bus.stall        = rst ? stall_c     : 6'b000000;
    assign bus.lu_hazard    = rst ? lu_hazard_c : 1'b0;
    assign bus.mc_busy      = rst ? mc_busy_c   : 1'b0;
    assign bus.mc_done      = rst ? mc_done_c   : 1'b0;
    assign bus.stall_cycles = rst ? stall_cycles_q : 16'd0;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboarded bench for pipe_stall_ctrl: unit a (LU_PENALTY=1, MC_CYCLES=32), unit b (LU_PENALTY=3).
module tb_pipe_stall_ctrl;

    typedef struct packed {
        logic [5:0]  stall;
        logic        lu;
        logic        busy;
        logic        done;
        logic [15:0] sc;
    } exp_t;

    logic clk;
    logic rst;

    pipe_stall_ctrl_if bi_a ();
    pipe_stall_ctrl_if bi_b ();

    pipe_stall_ctrl #(.LU_PENALTY(1), .MC_CYCLES(32)) u_a (.clk(clk), .rst(rst), .bus(bi_a));
    pipe_stall_ctrl #(.LU_PENALTY(3), .MC_CYCLES(32)) u_b (.clk(clk), .rst(rst), .bus(bi_b));

    int          n_cmp = 0;
    int          n_err = 0;
    int          s2_cnt_b = 0;
    logic [15:0] exp_sc [2];
    exp_t        q_a [$];
    exp_t        q_b [$];
    string       t_a [$];
    string       t_b [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_outs(input string tag, input logic [5:0] s, input logic lu, input logic bu,
                            input logic dn, input logic [15:0] sc, input exp_t e);
        chk({tag, ".stall"}, 32'(s),  32'(e.stall));
        chk({tag, ".lu"},    32'(lu), 32'(e.lu));
        chk({tag, ".busy"},  32'(bu), 32'(e.busy));
        chk({tag, ".done"},  32'(dn), 32'(e.done));
        chk({tag, ".sc"},    32'(sc), 32'(e.sc));
    endtask

    // Push what unit u must show this cycle, then advance to just after the next posedge.
    task automatic tick(input int u, input string tag, input logic [5:0] s,
                        input logic lu, input logic bu, input logic dn);
        exp_t e;
        e = '{stall: s, lu: lu, busy: bu, done: dn, sc: exp_sc[u]};
        if (s[0] && (exp_sc[u] != 16'hFFFF)) exp_sc[u] = exp_sc[u] + 16'd1;
        if (u == 0) begin
            q_a.push_back(e);
            t_a.push_back(tag);
        end else begin
            q_b.push_back(e);
            t_b.push_back(tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        bi_a.ex_load = 0; bi_a.ex_waddr = 0; bi_a.id_rs = 0; bi_a.id_rt = 0;
        bi_a.id_rs_used = 0; bi_a.id_rt_used = 0; bi_a.ex_mc_op = 0; bi_a.mem_stallreq = 0;
        bi_b.ex_load = 0; bi_b.ex_waddr = 0; bi_b.id_rs = 0; bi_b.id_rt = 0;
        bi_b.id_rs_used = 0; bi_b.id_rt_used = 0; bi_b.ex_mc_op = 0; bi_b.mem_stallreq = 0;
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string t;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            t = t_a.pop_front();
            cmp_outs(t, bi_a.stall, bi_a.lu_hazard, bi_a.mc_busy, bi_a.mc_done, bi_a.stall_cycles, e);
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            t = t_b.pop_front();
            cmp_outs(t, bi_b.stall, bi_b.lu_hazard, bi_b.mc_busy, bi_b.mc_done, bi_b.stall_cycles, e);
            if (bi_b.stall[2]) s2_cnt_b++;
        end
    end

    initial begin
        exp_sc[0] = 16'd0;
        exp_sc[1] = 16'd0;
        rst = 1'b0;
        zero_inputs();
        #3;
        chk("rst.stall", 32'(bi_a.stall), 32'd0);
        chk("rst.lu",    32'(bi_a.lu_hazard), 32'd0);
        chk("rst.busy",  32'(bi_a.mc_busy), 32'd0);
        chk("rst.done",  32'(bi_a.mc_done), 32'd0);
        chk("rst.sc",    32'(bi_a.stall_cycles), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Load-use on rs, one bubble, then the load moves on.
        bi_a.ex_load = 1; bi_a.ex_waddr = 5; bi_a.id_rs = 5; bi_a.id_rs_used = 1;
        tick(0, "lu1", 6'b000111, 1, 0, 0);
        bi_a.ex_load = 0;
        tick(0, "lu1_after", 6'b000000, 0, 0, 0);

        // No hazard: r0 destination, or rs not actually read.
        bi_a.ex_load = 1; bi_a.ex_waddr = 0; bi_a.id_rs = 0; bi_a.id_rs_used = 1;
        tick(0, "nz_r0", 6'b000000, 0, 0, 0);
        bi_a.ex_waddr = 5; bi_a.id_rs = 5; bi_a.id_rs_used = 0;
        tick(0, "nz_unused", 6'b000000, 0, 0, 0);
        bi_a.ex_load = 0; bi_a.id_rs_used = 1;
        tick(0, "nz_noload", 6'b000000, 0, 0, 0);

        // Hazard via rt, first masked by a memory stall.
        bi_a.ex_load = 1; bi_a.id_rs = 9; bi_a.id_rt = 5; bi_a.id_rt_used = 1;
        bi_a.mem_stallreq = 1;
        tick(0, "lu_rt_mem", 6'b011111, 0, 0, 0);
        bi_a.mem_stallreq = 0;
        tick(0, "lu_rt", 6'b000111, 1, 0, 0);
        bi_a.ex_load = 0;
        tick(0, "lu_rt_after", 6'b000000, 0, 0, 0);
        bi_a.id_rs_used = 0; bi_a.id_rt_used = 0;

        // Multi-cycle op, no memory stall: 32 stall cycles then one mc_done.
        bi_a.ex_mc_op = 1;
        for (int c = 1; c <= 32; c++) tick(0, $sformatf("mc%0d", c), 6'b001111, 0, 1, 0);
        tick(0, "mc_done", 6'b000000, 0, 0, 1);
        bi_a.ex_mc_op = 0;
        tick(0, "mc_idle", 6'b000000, 0, 0, 0);

        // Multi-cycle op with mem_stallreq over cycles 30..35.
        bi_a.ex_mc_op = 1;
        for (int c = 1; c <= 36; c++) begin
            logic       m;
            logic [5:0] s;
            m = (c >= 30) && (c <= 35);
            bi_a.mem_stallreq = m;
            s = m ? 6'b011111 : ((c <= 32) ? 6'b001111 : 6'b000000);
            tick(0, $sformatf("mcm%0d", c), s, 0, (c <= 32), (c >= 33));
        end
        bi_a.ex_mc_op = 0;
        bi_a.mem_stallreq = 0;
        tick(0, "mcm_idle", 6'b000000, 0, 0, 0);

        // Three-bubble load-use with a 2-cycle memory stall in the middle.
        bi_b.ex_load = 1; bi_b.ex_waddr = 7; bi_b.id_rs = 7; bi_b.id_rs_used = 1;
        tick(1, "lu3_c1", 6'b000111, 1, 0, 0);
        tick(1, "lu3_c2", 6'b000111, 1, 0, 0);
        bi_b.mem_stallreq = 1;
        tick(1, "lu3_c3", 6'b011111, 1, 0, 0);
        tick(1, "lu3_c4", 6'b011111, 1, 0, 0);
        bi_b.mem_stallreq = 0;
        tick(1, "lu3_c5", 6'b000111, 1, 0, 0);
        bi_b.ex_load = 0;
        tick(1, "lu3_c6", 6'b000000, 0, 0, 0);
        chk("lu3_stall2_cycles", 32'(s2_cnt_b), 32'd5);

        // Reset in cycle 10 of an MC op.
        bi_a.ex_mc_op = 1;
        for (int c = 1; c <= 9; c++) tick(0, $sformatf("mcr%0d", c), 6'b001111, 0, 1, 0);
        bi_a.mem_stallreq = 1;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.stall", 32'(bi_a.stall), 32'd0);
        chk("arst.lu",    32'(bi_a.lu_hazard), 32'd0);
        chk("arst.busy",  32'(bi_a.mc_busy), 32'd0);
        chk("arst.done",  32'(bi_a.mc_done), 32'd0);
        chk("arst.sc",    32'(bi_a.stall_cycles), 32'd0);
        @(posedge clk);
        @(posedge clk);
        zero_inputs();
        #1;
        rst = 1'b1;
        exp_sc[0] = 16'd0;
        exp_sc[1] = 16'd0;
        for (int c = 1; c <= 3; c++) tick(0, $sformatf("post_rst%0d", c), 6'b000000, 0, 0, 0);

        // Saturation of the stall-cycle counter.
        bi_a.mem_stallreq = 1;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat.sc", 32'(bi_a.stall_cycles), 32'hFFFF);
        chk("sat.stall", 32'(bi_a.stall), 32'b011111);
        bi_a.mem_stallreq = 0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
